branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_pkg.sv | 15 +
 rtl/branch_resolve_queue_if.sv | 34 +++
 rtl/branch_resolve_queue_fifo.sv | 49 ++++
 rtl/branch_resolve_queue.sv | 93 +++++++++
 tb/tb_branch_resolve_queue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_pkg;

    localparam int BRQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        pred;
    } brq_entry_t;

    function automatic logic is_mispredict(brq_entry_t entry, logic taken);
        return entry.pred != taken;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing signal bundle of the branch resolve queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = branch_pkg::BRQ_DEPTH_DEFAULT
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic [31:0]       push_addr;
    logic              push_pred;
    logic              push_ready;
    logic              res_valid;
    logic              res_taken;
    logic              record_result;
    logic [31:0]       resolve_addr;
    logic              resolve_taken;
    logic              mispredict;
    logic [CW-1:0]     count;
    logic [31:0]       branch_count;
    logic [31:0]       mispredict_count;
    logic              underflow_err;

    modport master (
        output push_valid, push_addr, push_pred, res_valid, res_taken,
        input  push_ready, record_result, resolve_addr, resolve_taken, mispredict,
               count, branch_count, mispredict_count, underflow_err
    );

    modport slave (
        input  push_valid, push_addr, push_pred, res_valid, res_taken,
        output push_ready, record_result, resolve_addr, resolve_taken, mispredict,
               count, branch_count, mispredict_count, underflow_err
    );

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// Flop-based FIFO of in-flight branches: push at tail, pop at head, synchronous clear.
module brq_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  brq_entry_t                 push_entry,
    input  logic                       pop,
    output brq_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    brq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately unreset; occupancy alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in order, trains the predictor on resolve and flushes on mispredict.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    branch_resolve_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    brq_entry_t    head_entry;
    logic          res_accept;
    logic          mis_accept;
    logic          push_accept;

    logic          record_q, record_d;
    logic [31:0]   addr_q, addr_d;
    logic          taken_q, taken_d;
    logic          mis_q, mis_d;
    logic [31:0]   branch_count_q, branch_count_d;
    logic [31:0]   mispredict_count_q, mispredict_count_d;
    logic          underflow_q, underflow_d;

    assign bus.push_ready = (count != CW'(DEPTH));
    assign res_accept     = bus.res_valid && (count != '0);
    assign mis_accept     = res_accept && is_mispredict(head_entry, bus.res_taken);
    // A mispredict flushes the queue, so a same-cycle push is dropped with it.
    assign push_accept    = bus.push_valid && bus.push_ready && !mis_accept;

    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (mis_accept),
        .push       (push_accept),
        .push_entry ('{addr: bus.push_addr, pred: bus.push_pred}),
        .pop        (res_accept && !mis_accept),
        .head_entry (head_entry),
        .count      (count)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        record_d           = res_accept;
        addr_d             = '0;
        taken_d            = 1'b0;
        mis_d              = mis_accept;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        underflow_d        = underflow_q | (bus.res_valid && (count == '0));
        if (res_accept) begin
            addr_d  = head_entry.addr;
            taken_d = bus.res_taken;
            if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
        end
        if (mis_accept && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            record_q           <= 1'b0;
            addr_q             <= '0;
            taken_q            <= 1'b0;
            mis_q              <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            underflow_q        <= 1'b0;
        end else begin
            record_q           <= record_d;
            addr_q             <= addr_d;
            taken_q            <= taken_d;
            mis_q              <= mis_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            underflow_q        <= underflow_d;
        end
    end

    assign bus.record_result    = record_q;
    assign bus.resolve_addr     = addr_q;
    assign bus.resolve_taken    = taken_q;
    assign bus.mispredict       = mis_q;
    assign bus.count            = count;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
    assign bus.underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and random stimulus against a queue-based reference model of the branch resolve queue.
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH)) bus ();

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: in-order list of {addr, pred}, plus statistics.
    logic [32:0] mq[$];
    logic [31:0] m_branch;
    logic [31:0] m_mis;
    logic        m_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_branch = '0;
        m_mis    = '0;
        m_uf     = 1'b0;
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_count"},     32'(bus.count), 32'd0);
        check({phase, "_record"},    32'(bus.record_result), 32'd0);
        check({phase, "_addr"},      bus.resolve_addr, 32'd0);
        check({phase, "_taken"},     32'(bus.resolve_taken), 32'd0);
        check({phase, "_mispred"},   32'(bus.mispredict), 32'd0);
        check({phase, "_brcnt"},     bus.branch_count, 32'd0);
        check({phase, "_miscnt"},    bus.mispredict_count, 32'd0);
        check({phase, "_underflow"}, 32'(bus.underflow_err), 32'd0);
    endtask

    // One clock of stimulus; called just after a rising edge, checks just after the next one.
    task automatic step(input logic pv, input logic [31:0] pa, input logic pp,
                        input logic rv, input logic rt);
        logic        acc;
        logic        mis;
        logic [32:0] head;
        int          sz;
        bus.push_valid = pv;
        bus.push_addr  = pa;
        bus.push_pred  = pp;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        sz   = mq.size();
        acc  = rv && (sz != 0);
        mis  = 1'b0;
        head = '0;
        check("push_ready", 32'(bus.push_ready), 32'(sz != DEPTH));
        if (acc) begin
            head = mq[0];
            mis  = (head[0] != rt);
            if (m_branch != 32'hFFFF_FFFF) m_branch = m_branch + 1;
            if (mis) begin
                if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
                mq.delete();
            end else begin
                void'(mq.pop_front());
            end
        end
        if (rv && sz == 0) m_uf = 1'b1;
        if (pv && sz != DEPTH && !mis) mq.push_back({pa, pp});
        @(posedge clk);
        #1;
        check("record_result", 32'(bus.record_result), 32'(acc));
        check("resolve_addr",  bus.resolve_addr, acc ? head[32:1] : 32'd0);
        check("resolve_taken", 32'(bus.resolve_taken), 32'(acc && rt));
        check("mispredict",    32'(bus.mispredict), 32'(mis));
        check("count",         32'(bus.count), 32'(mq.size()));
        check("branch_count",  bus.branch_count, m_branch);
        check("mispred_count", bus.mispredict_count, m_mis);
        check("underflow_err", 32'(bus.underflow_err), 32'(m_uf));
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] base;
        reset_n        = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_addr  = '0;
        bus.push_pred  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        model_reset();
        #1;
        check_all_zero("por");
        check("por_push_ready", 32'(bus.push_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single correct resolve.
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("s1_addr", bus.resolve_addr, 32'h100);
        check("s1_brcnt", bus.branch_count, 32'd1);
        idle();

        // Mispredict flushes younger entries, then resolve on empty queue.
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h20C, 1'b1, 1'b1, 1'b1);
        check("s2_addr", bus.resolve_addr, 32'h200);
        check("s2_count", 32'(bus.count), 32'd0);
        idle();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("s2_underflow", 32'(bus.underflow_err), 32'd1);

        // Fill, overflow attempt, in-order drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Correct resolve concurrent with push keeps occupancy.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3ABC, 1'b1, 1'b1, 1'b0);
        check("s4_count", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("s4_addr", bus.resolve_addr, 32'h3ABC);

        // Full queue with a mispredict and a push in the same cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4F00, 1'b1, 1'b1, 1'b1);

        // Mid-stream asynchronous reset with a record_result pending.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h5000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("s5_count", 32'(bus.count), 32'd5);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        #2;
        reset_n = 1'b1;
        model_reset();
        check("post_rst_ready", 32'(bus.push_ready), 32'd1);
        check("post_rst_count", 32'(bus.count), 32'd0);
        step(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Saturation of the mispredict counter.
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count_q;
        m_mis = 32'hFFFF_FFFF;
        check("sat_preload", bus.mispredict_count, 32'hFFFF_FFFF);
        step(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("sat_hold", bus.mispredict_count, 32'hFFFF_FFFF);

        // Random traffic, alternating push-heavy and resolve-heavy phases.
        for (int i = 0; i < 600; i++) begin
            base = ((i / 50) % 2 == 0) ? 32'd80 : 32'd35;
            step(($urandom_range(99) < base), $urandom, 1'($urandom),
                 ($urandom_range(99) < 32'd115 - base), 1'($urandom_range(9) != 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
